// File: rtl/jbasicgates_pkg.sv
// jbasicgates_pkg: shared definitions for the jbasicgates self-test engine.
//   - state_t      : BIST sequencer states
//   - EXP_*        : golden gate outputs {OR,AND,XOR,NOR,NAND,XNOR} per {a,b}
//   - IDX_*        : bit positions of each gate inside the 6-bit output word
//   - exp_out()    : golden lookup by vector index
package jbasicgates_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int IDX_OR   = 5;
    localparam int IDX_AND  = 4;
    localparam int IDX_XOR  = 3;
    localparam int IDX_NOR  = 2;
    localparam int IDX_NAND = 1;
    localparam int IDX_XNOR = 0;

    localparam logic [5:0] EXP_00 = 6'b000111;
    localparam logic [5:0] EXP_01 = 6'b101010;
    localparam logic [5:0] EXP_10 = 6'b101010;
    localparam logic [5:0] EXP_11 = 6'b110001;

    function automatic logic [5:0] exp_out(input logic [1:0] vec);
        logic [5:0] r;
        case (vec)
            2'd0:    r = EXP_00;
            2'd1:    r = EXP_01;
            2'd2:    r = EXP_10;
            default: r = EXP_11;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jbist_settle_timer.sv
// jbist_settle_timer: 4-bit loadable down-counter used to hold each stimulus
// vector for a fixed number of clocks before the outputs are sampled.
// Ports:
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   i_load     : load i_val (has priority over i_dec)
//   i_val      : value to load
//   i_dec      : decrement by one; holds at zero
//   o_zero     : count is zero
module jbist_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= 4'd0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && (r_cnt != 4'd0))
            r_cnt <= r_cnt - 4'd1;
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/jbasicgates_bist.sv
// jbasicgates_bist: on-chip self-test engine for the jbasicgates block.
// Walks {a,b} through 00,01,10,11, holds each vector SETTLE_CYCLES clocks,
// then samples y_obs for one clock and compares with the golden table.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a run (accepted only in IDLE / DONE)
//   a, b        : stimulus to the gate block
//   y_obs       : gate outputs {OR,AND,XOR,NOR,NAND,XNOR}
//   inject      : (JBIST_FAULT_INJECT_EN only) invert the XOR bit before compare
//   busy, done  : run in progress / sticky run-complete
//   pass        : all vectors matched (valid with done)
//   fail_mask   : bit v set when vector v mismatched
//   err_count   : number of failing vectors (0..4)
//   first_bad   : compared word at the first failing vector, else 0
// Configuration macro: JBIST_FAULT_INJECT_EN adds the inject port.
module jbasicgates_bist
    import jbasicgates_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4   // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [5:0] y_obs,
`ifdef JBIST_FAULT_INJECT_EN
    input  logic       inject,
`endif
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count,
    output logic [5:0] first_bad
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_vec;
    logic [3:0] r_fail_mask;
    logic [2:0] r_err;
    logic [5:0] r_first_bad;
    logic       r_pass;

    logic       w_start_acc;
    logic       w_tmr_load;
    logic       w_tmr_dec;
    logic       w_tmr_zero;
    logic       w_check;
    logic       w_busy;
    logic       w_done;
    logic [5:0] w_y_cmp;
    logic       w_mis;
    logic [2:0] w_err_next;

`ifdef JBIST_FAULT_INJECT_EN
    // Flip only the XOR output so a healthy gate block fails every vector.
    assign w_y_cmp = y_obs ^ (inject ? (6'd1 << IDX_XOR) : 6'd0);
`else
    assign w_y_cmp = y_obs;
`endif

    assign w_mis      = (w_y_cmp != exp_out(r_vec));
    assign w_err_next = (w_mis && (r_err != 3'd4)) ? r_err + 3'd1 : r_err;

    jbist_settle_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_tmr_load),
        .i_val  (SETTLE_LOAD),
        .i_dec  (w_tmr_dec),
        .o_zero (w_tmr_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start)      w_next = DRIVE;
            DRIVE:      if (w_tmr_zero) w_next = CHECK;
            CHECK:      w_next = (r_vec == 2'd3) ? DONE : DRIVE;
            default:    w_next = IDLE;
        endcase
    end

    // Control strobes and status
    always_comb begin
        w_start_acc = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        w_check     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_acc = start;
                w_tmr_load  = start;
            end
            DONE: begin
                w_done      = 1'b1;
                w_start_acc = start;
                w_tmr_load  = start;
            end
            DRIVE: begin
                w_busy    = 1'b1;
                w_tmr_dec = 1'b1;
            end
            CHECK: begin
                w_busy     = 1'b1;
                w_check    = 1'b1;
                // Reload for the next vector; the last check leaves the timer idle.
                w_tmr_load = (r_vec != 2'd3);
            end
            default: ;
        endcase
    end

    // Vector index and result registers. r_vec stays at 3 in DONE so {a,b}
    // holds 2'b11 until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec       <= 2'd0;
            r_fail_mask <= 4'd0;
            r_err       <= 3'd0;
            r_first_bad <= 6'd0;
            r_pass      <= 1'b0;
        end else if (w_start_acc) begin
            r_vec       <= 2'd0;
            r_fail_mask <= 4'd0;
            r_err       <= 3'd0;
            r_first_bad <= 6'd0;
            r_pass      <= 1'b0;
        end else if (w_check) begin
            if (w_mis) begin
                r_fail_mask[r_vec] <= 1'b1;
                r_err              <= w_err_next;
                if (r_err == 3'd0)
                    r_first_bad <= w_y_cmp;
            end
            if (r_vec == 2'd3)
                r_pass <= (w_err_next == 3'd0);
            else
                r_vec <= r_vec + 2'd1;
        end
    end

    assign a         = r_vec[1];
    assign b         = r_vec[0];
    assign busy      = w_busy;
    assign done      = w_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign err_count = r_err;
    assign first_bad = r_first_bad;

endmodule

// File: tb/tb_jbasicgates_bist.sv
module tb_jbasicgates_bist;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a, b;
    logic [5:0] y_obs;
    logic       inject = 1'b0;
    logic       busy, done, pass;
    logic [3:0] fail_mask;
    logic [2:0] err_count;
    logic [5:0] first_bad;

    // Gate-block model: mode 0 = golden ^ per-vector corruption,
    // 1 = AND stuck-at-0, 2 = NOR/NAND outputs swapped.
    logic [1:0]      mode = 2'd0;
    logic [3:0][5:0] corr = '0;

    int  errors = 0;
    int  checks = 0;
    longint cyc = 0;

    typedef struct {
        logic [3:0] fm;
        logic [2:0] ec;
        logic [5:0] fb;
        logic       ps;
        longint     dcyc;
    } exp_t;
    exp_t q[$];

    jbasicgates_bist #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .y_obs     (y_obs),
`ifdef JBIST_FAULT_INJECT_EN
        .inject    (inject),
`endif
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .err_count (err_count),
        .first_bad (first_bad)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] gold(input logic aa, input logic bb);
        return {aa | bb, aa & bb, aa ^ bb, ~(aa | bb), ~(aa & bb), ~(aa ^ bb)};
    endfunction

    function automatic logic [5:0] blk(input logic aa, input logic bb,
                                       input logic [1:0] md, input logic [3:0][5:0] cr);
        logic [5:0] g;
        g = gold(aa, bb);
        case (md)
            2'd1:    return {g[5], 1'b0, g[3:0]};
            2'd2:    return {g[5:3], g[1], g[2], g[0]};
            default: return g ^ cr[{aa, bb}];
        endcase
    endfunction

    always @* y_obs = blk(a, b, mode, corr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected result of one run computed straight from the gate truth table.
    function automatic exp_t predict(input longint done_cyc);
        exp_t e;
        logic [5:0] act;
        e.fm = '0; e.ec = '0; e.fb = '0; e.dcyc = done_cyc;
        for (int v = 0; v < 4; v++) begin
            logic aa, bb;
            aa  = (v >= 2);
            bb  = (v % 2 == 1);
            act = blk(aa, bb, mode, corr) ^ (inject ? 6'b001000 : 6'b000000);
            if (act !== gold(aa, bb)) begin
                if (e.ec == 0) e.fb = act;
                e.fm[v] = 1'b1;
                e.ec    = e.ec + 3'd1;
            end
        end
        e.ps = (e.ec == 0);
        return e;
    endfunction

    // Monitor: records the {a,b} walk while busy, checks on each done rise.
    logic [1:0] seq[$];
    logic       prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            seq.delete();
            prev_done = 1'b0;
        end else begin
            if (busy && (seq.size() == 0 || seq[$] != {a, b}))
                seq.push_back({a, b});
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency",   32'(cyc),       32'(e.dcyc));
                    chk("pass",      32'(pass),      32'(e.ps));
                    chk("fail_mask", 32'(fail_mask), 32'(e.fm));
                    chk("err_count", 32'(err_count), 32'(e.ec));
                    chk("first_bad", 32'(first_bad), 32'(e.fb));
                    chk("ab_hold11", 32'({a, b}),    32'd3);
                    chk("seq_len",   32'(seq.size()), 32'd4);
                    for (int i = 0; i < 4 && i < seq.size(); i++)
                        chk("seq_val", 32'(seq[i]), 32'(i));
                end
                seq.delete();
            end
            prev_done = done;
        end
    end

    task automatic kick();
        q.push_back(predict(cyc + 1 + 4 * (S + 1)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        chk("timeout", 32'(q.size()), 32'd0);
        q.delete();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_pass"},  32'(pass),      32'd0);
        chk({tag, "_fm"},    32'(fail_mask), 32'd0);
        chk({tag, "_ec"},    32'(err_count), 32'd0);
        chk({tag, "_fb"},    32'(first_bad), 32'd0);
        chk({tag, "_ab"},    32'({a, b}),    32'd0);
    endtask

    task automatic run(input logic [1:0] md, input logic [3:0][5:0] cr, input bit poke);
        @(negedge clk);
        mode = md;
        corr = cr;
        kick();
        if (poke) begin
            repeat (7) @(negedge clk);
            start = 1'b1;          // must be ignored while busy
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
        chk("done_sticky", 32'(done), 32'd1);
    endtask

    initial begin
        logic [3:0][5:0] cr;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed: healthy, AND stuck-at-0, NOR/NAND swapped, mid-run start.
        run(2'd0, '0, 1'b0);
        run(2'd1, '0, 1'b0);
        run(2'd2, '0, 1'b0);
        run(2'd0, '0, 1'b1);

        // Reset during vector 2 DRIVE aborts the run and clears everything.
        @(negedge clk);
        mode = 2'd0; corr = '0;
        kick();
        for (int i = 0; i < 100 && !(busy && {a, b} == 2'b10); i++) @(negedge clk);
        chk("reach_vec2", 32'({a, b}), 32'd2);
        void'(q.pop_back());
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        rst_n = 1'b1;
        repeat (S * 6) @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        run(2'd0, '0, 1'b0);

        // Held start: immediate restart one clock after done.
        @(negedge clk);
        mode = 2'd0; corr[2] = 6'b010101; corr[0] = '0; corr[1] = '0; corr[3] = '0;
        q.push_back(predict(cyc + 1 + 4 * (S + 1)));
        q.push_back(predict(cyc + 2 + 8 * (S + 1)));
        start = 1'b1;
        for (int i = 0; i < 200 && q.size() > 1; i++) @(negedge clk);
        @(negedge clk);
        chk("restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_idle();

        // Randomized per-vector corruption of the gate outputs.
        for (int r = 0; r < 16; r++) begin
            for (int v = 0; v < 4; v++)
                cr[v] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
            run(2'd0, cr, ($urandom_range(0, 3) == 0));
        end

`ifdef JBIST_FAULT_INJECT_EN
        inject = 1'b1;
        run(2'd0, '0, 1'b0);
        inject = 1'b0;
        run(2'd0, '0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
